// File: rtl/ps2_cmd_scheduler.sv
// Host-to-keyboard command sequencer: arbitrates LED / typematic requesters onto one
// PS/2 byte transmitter, sends opcode + argument, and waits for the keyboard ACK after each byte.
module ps2_cmd_scheduler #(
  parameter logic [7:0] CMD0      = 8'hED,
  parameter logic [7:0] CMD1      = 8'hF3,
  parameter int         TIMEOUT   = 250000,
  parameter int         CNT_W     = 18,
  parameter int         MAX_RETRY = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic [7:0] i_arg0,
  input  logic [7:0] i_arg1,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  input  logic       i_tx_done,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_rx_owned,
  output logic       o_busy,
  output logic [1:0] o_done,
  output logic [1:0] o_err
);

  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
  localparam logic [RTY_W-1:0] RMAX = RTY_W'(MAX_RETRY);
  localparam logic [7:0] KBD_ACK    = 8'hFA;
  localparam logic [7:0] KBD_RESEND = 8'hFE;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_TX, S_WAIT_ACK, S_DONE, S_ERROR
  } state_t;

  state_t             state_q, state_n;
  logic               phase_q, phase_n;   // 0: opcode byte, 1: argument byte
  logic               id_q, id_n;
  logic [7:0]         arg_q, arg_n;
  logic [RTY_W-1:0]   retry_q, retry_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               last_q, last_n;
  logic               grant;
  logic               rx_ack, rx_resend;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      id_q    <= 1'b0;
      arg_q   <= 8'h00;
      retry_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_n;
      phase_q <= phase_n;
      id_q    <= id_n;
      arg_q   <= arg_n;
      retry_q <= retry_n;
      cnt_q   <= cnt_n;
      last_q  <= last_n;
    end
  end

  // Transmitter handshake: o_tx_start is a one-cycle pulse with o_tx_data valid in
  // the same cycle; the transmitter answers with a one-cycle i_tx_done pulse later.
  always_comb begin
    state_n    = state_q;
    phase_n    = phase_q;
    id_n       = id_q;
    arg_n      = arg_q;
    retry_n    = retry_q;
    cnt_n      = cnt_q;
    last_n     = last_q;
    grant      = 1'b0;
    o_tx_data  = 8'h00;
    o_tx_start = 1'b0;
    o_rx_owned = 1'b0;
    o_done     = 2'b00;
    o_err      = 2'b00;
    rx_ack     = i_rx_valid && (i_rx_data == KBD_ACK);
    rx_resend  = i_rx_valid && (i_rx_data == KBD_RESEND);
    case (state_q)
      S_IDLE: begin
        if (|i_req) begin
          grant   = (i_req == 2'b11) ? ~last_q : i_req[1];
          id_n    = grant;
          arg_n   = grant ? i_arg1 : i_arg0;
          phase_n = 1'b0;
          retry_n = '0;
          last_n  = grant;
          state_n = S_SEND;
        end
      end
      S_SEND: begin
        o_tx_start = 1'b1;
        o_tx_data  = phase_q ? arg_q : (id_q ? CMD1 : CMD0);
        cnt_n      = '0;
        state_n    = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (i_tx_done) begin
          cnt_n   = '0;
          state_n = S_WAIT_ACK;
        end else if (cnt_q == TMO) begin
          state_n = S_ERROR;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_ACK: begin
        o_rx_owned = 1'b1;
        // A received ACK/resend outranks a timeout expiring in the same cycle.
        if (rx_ack) begin
          if (phase_q) begin
            state_n = S_DONE;
          end else begin
            phase_n = 1'b1;
            state_n = S_SEND;
          end
        end else if (rx_resend || (cnt_q == TMO)) begin
          if (retry_q < RMAX) begin
            retry_n = retry_q + RTY_W'(1);
            state_n = S_SEND;
          end else begin
            state_n = S_ERROR;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        o_done[id_q] = 1'b1;
        state_n      = S_IDLE;
      end
      S_ERROR: begin
        o_err[id_q] = 1'b1;
        state_n     = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Bench for ps2_cmd_scheduler: directed and random keyboard/transmitter behaviour
// checked against a transaction-level model of the command protocol.
module tb_ps2_cmd_scheduler;

  localparam int T    = 30;
  localparam int MAXR = 3;
  localparam int R_ACK  = 0;
  localparam int R_FE   = 1;
  localparam int R_SIL  = 2;
  localparam int R_FGN  = 3;
  localparam int R_HANG = 4;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [1:0] i_req = 2'b00;
  logic [7:0] i_arg0 = 8'h00;
  logic [7:0] i_arg1 = 8'h00;
  logic       i_tx_done = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_valid = 1'b0;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       o_rx_owned;
  logic       o_busy;
  logic [1:0] o_done;
  logic [1:0] o_err;

  always #5 clk = ~clk;

  ps2_cmd_scheduler #(.TIMEOUT(T), .CNT_W(6), .MAX_RETRY(MAXR)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_arg0(i_arg0), .i_arg1(i_arg1),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_owned(o_rx_owned),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         script_q[$];
  logic       model_last = 1'b1;
  bit         rand_mode = 1'b0;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rand_resp();
    int v;
    v = $urandom_range(0, 99);
    if (v < 50) return R_ACK;
    if (v < 70) return R_FE;
    if (v < 80) return R_SIL;
    if (v < 95) return R_FGN;
    return R_HANG;
  endfunction

  // Protocol model: walk the keyboard responses, listing the bytes the host must send.
  task automatic model_txn(input logic [7:0] op, input logic [7:0] a, output bit ok);
    int k;
    int retry;
    bit phase;
    bit fin;
    k = 0; retry = 0; phase = 0; fin = 0; ok = 0;
    exp_q.delete();
    while (!fin) begin
      int r;
      if (k >= script_q.size()) script_q.push_back(rand_mode ? rand_resp() : R_ACK);
      r = script_q[k];
      k++;
      exp_q.push_back(phase ? a : op);
      if (r == R_HANG) fin = 1;
      else if (r == R_ACK || r == R_FGN) begin
        if (phase) begin ok = 1; fin = 1; end
        else phase = 1;
      end else if (retry < MAXR) retry++;
      else fin = 1;
    end
  endtask

  task automatic wait_evt(output int kind);
    kind = 0;
    for (int i = 0; i < 4 * T + 100; i++) begin
      if (o_tx_start) begin kind = 1; break; end
      if (o_done != 2'b00 || o_err != 2'b00) begin kind = 2; break; end
      tick();
    end
  endtask

  task automatic pulse_done();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] d);
    i_rx_data  = d;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [1:0] rq, input logic [7:0] a0, input logic [7:0] a1,
                         input bit keep);
    logic       id;
    logic [7:0] op;
    logic [7:0] a;
    bit         ok;
    int         kind;
    int         k;
    int         r;
    int         mark;
    int         d;
    id = (rq == 2'b11) ? ~model_last : rq[1];
    model_last = id;
    op = id ? 8'hF3 : 8'hED;
    a  = id ? a1 : a0;
    model_txn(op, a, ok);
    i_req = rq; i_arg0 = a0; i_arg1 = a1;
    k = 0;
    wait_evt(kind);
    while (kind == 1) begin
      if (!keep) begin
        i_req = 2'b00; i_arg0 = 8'($urandom); i_arg1 = 8'($urandom);
      end
      if (k >= exp_q.size()) begin
        chk("extra_tx", k, exp_q.size());
        break;
      end
      chk("tx_data", o_tx_data, exp_q[k]);
      r = script_q[k];
      k++;
      mark = cyc;
      tick();
      if (r == R_HANG) begin
        wait_evt(kind);
        chk("hang_gap", cyc - mark, T + 2);
      end else begin
        d = $urandom_range(0, 8);
        repeat (d) tick();
        chk("owned_in_tx", o_rx_owned, 0);
        pulse_done();
        chk("owned_in_ack", o_rx_owned, 1);
        mark = cyc;
        if (r != R_SIL) begin
          d = $urandom_range(0, 8);
          repeat (d) tick();
        end
        case (r)
          R_ACK: pulse_rx(8'hFA);
          R_FE:  pulse_rx(8'hFE);
          R_FGN: begin
            pulse_rx(8'h1D);
            chk("owned_after_fgn", o_rx_owned, 1);
            pulse_rx(8'hFA);
          end
          default: ;
        endcase
        wait_evt(kind);
        if (r == R_SIL) chk("ack_tmo_gap", cyc - mark, T + 1);
      end
    end
    if (kind == 2) begin
      chk("done", o_done, ok ? (id ? 32'd2 : 32'd1) : 32'd0);
      chk("err", o_err, ok ? 32'd0 : (id ? 32'd2 : 32'd1));
      chk("n_tx", k, exp_q.size());
      if (!keep) i_req = 2'b00;
      tick();
      chk("busy_after", o_busy, 0);
    end else begin
      chk("end_evt", kind, 2);
      i_req = 2'b00; i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      model_last = 1'b1;
    end
  endtask

  initial begin
    int kind;
    repeat (3) tick();
    i_rst = 1'b0;
    chk("reset_outs", {o_tx_data, o_tx_start, o_rx_owned, o_busy, o_done, o_err}, 0);

    script_q = '{R_ACK, R_ACK};
    run_txn(2'b01, 8'h07, 8'h00, 0);

    script_q = '{R_ACK, R_ACK};
    run_txn(2'b11, 8'h11, 8'h22, 1);
    script_q = '{R_ACK, R_ACK};
    run_txn(2'b11, 8'h11, 8'h22, 1);
    script_q = '{R_ACK, R_ACK};
    run_txn(2'b11, 8'h11, 8'h22, 0);

    script_q = '{R_ACK, R_FE, R_FE, R_ACK};
    run_txn(2'b10, 8'h00, 8'h20, 0);

    script_q = '{R_SIL, R_SIL, R_SIL, R_SIL};
    run_txn(2'b01, 8'h03, 8'h00, 0);

    script_q = '{R_FGN, R_ACK};
    run_txn(2'b01, 8'h05, 8'h00, 0);

    script_q = '{R_HANG};
    run_txn(2'b10, 8'h00, 8'h0B, 0);

    script_q = '{R_FE, R_ACK, R_FE, R_SIL, R_FE};
    run_txn(2'b01, 8'h02, 8'h00, 0);

    // Reset while waiting for the ACK of the opcode.
    i_req = 2'b01; i_arg0 = 8'h55;
    wait_evt(kind);
    chk("rst_start", kind, 1);
    i_req = 2'b00;
    tick();
    pulse_done();
    chk("rst_owned", o_rx_owned, 1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    model_last = 1'b1;
    chk("rst_outs", {o_tx_data, o_tx_start, o_rx_owned, o_busy, o_done, o_err}, 0);
    repeat (3) begin
      tick();
      chk("rst_quiet", {o_busy, o_done, o_err}, 0);
    end
    script_q = '{R_ACK, R_ACK};
    run_txn(2'b11, 8'h44, 8'h66, 0);

    rand_mode = 1'b1;
    for (int n = 0; n < 14; n++) begin
      script_q.delete();
      run_txn(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    i_req = 2'b00;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
